// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and constants for the branch predict unit:
//                counter type, weak taken / weak not-taken counter values,
//                BTB entry layout and the next-PC source selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Default geometry; modules re-derive widths from their own parameters.
    localparam int unsigned DEF_ADDR_W      = 64;
    localparam int unsigned DEF_BTB_ENTRIES = 16;
    localparam int unsigned DEF_CTR_W       = 2;
    localparam int unsigned DEF_IDX_W       = $clog2(DEF_BTB_ENTRIES);
    localparam int unsigned DEF_TAG_W       = DEF_ADDR_W - DEF_IDX_W - 2;

    typedef logic [DEF_CTR_W-1:0] ctr_t;

    // Weakly taken sits just above the taken/not-taken midpoint,
    // weakly not-taken just below it.
    localparam ctr_t CTR_WEAK_T  = ctr_t'(1 << (DEF_CTR_W - 1));
    localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (DEF_CTR_W - 1)) - 1);

    typedef struct packed {
        logic                   valid;
        logic [DEF_TAG_W-1:0]   tag;
        logic [DEF_ADDR_W-1:0]  target;
        ctr_t                   ctr;
    } btb_entry_t;

    // Which source feeds the PC register, highest priority first.
    typedef enum logic [2:0] {
        SRC_EX   = 3'd0,
        SRC_ID   = 3'd1,
        SRC_HOLD = 3'd2,
        SRC_PRED = 3'd3,
        SRC_SEQ  = 3'd4
    } next_pc_src_e;

    // Counter value for "weakly taken" at an arbitrary counter width.
    function automatic int unsigned ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    // Counter value for "weakly not-taken" at an arbitrary counter width.
    function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_btb_array.sv
`default_nettype none
// ============================================================================
//  Module      : btb_array
//  Description : Direct-mapped branch target buffer with per-entry saturating
//                counters. One combinational lookup port, one synchronous
//                update port. A lookup always sees the contents as they were
//                before this cycle's update.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_array
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    // lookup port
    input  logic [ADDR_W-1:0] rd_pc_i,
    output logic              rd_taken_o,
    output logic [ADDR_W-1:0] rd_target_o,
    // update port
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] C_CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] C_CTR_MIN  = '0;
    localparam logic [CTR_W-1:0] C_CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] C_WEAK_T   = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] C_WEAK_NT  = CTR_W'(ctr_weak_not_taken(CTR_W));

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      target_q [BTB_ENTRIES];
    logic [CTR_W-1:0]       ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0]       rd_idx;
    logic [TAG_W-1:0]       rd_tag;
    logic                   rd_hit;

    logic [IDX_W-1:0]       upd_idx;
    logic [TAG_W-1:0]       upd_tag;
    logic                   upd_hit;
    logic [CTR_W-1:0]       upd_ctr;
    logic                   upd_we;
    logic [CTR_W-1:0]       upd_ctr_d;

    // Instructions are word aligned, so the two PC LSBs carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{rd_pc_i[1:0], upd_pc_i[1:0]};

    assign rd_idx  = rd_pc_i[IDX_W+1:2];
    assign rd_tag  = rd_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

    // Lookup: taken only on a valid tag match whose counter MSB is set.
    always_comb begin
        rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_taken_o  = rd_hit && ctr_q[rd_idx][CTR_W-1];
        rd_target_o = rd_taken_o ? target_q[rd_idx] : '0;
    end

    // Update decision: train on a hit, allocate on a taken miss, ignore a
    // not-taken miss so cold not-taken branches do not evict anything.
    always_comb begin
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctr   = ctr_q[upd_idx];
        upd_we    = 1'b0;
        upd_ctr_d = upd_ctr;
        if (upd_valid_i) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken_i) begin
                    upd_ctr_d = (upd_ctr == C_CTR_MAX) ? upd_ctr : upd_ctr + C_CTR_ONE;
                end else begin
                    upd_ctr_d = (upd_ctr == C_CTR_MIN) ? upd_ctr : upd_ctr - C_CTR_ONE;
                end
            end else if (upd_taken_i) begin
                upd_we    = 1'b1;
                upd_ctr_d = C_WEAK_T;
            end
        end
    end

    // Storage: reset clears every entry and takes priority over an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= C_WEAK_NT;
            end
        end else if (upd_we) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= upd_ctr_d;
            if (upd_taken_i) begin
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Next-PC / redirect unit. BTB prediction at IF, ID redirect
//                for unconditional branches, EX redirect on mispredict, with
//                flush outputs and a saturating mispredict counter. Purely
//                combinational from inputs to next_PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned CTR_W       = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_PC,
    input  logic [ADDR_W-1:0] PC_plus4,
    input  logic              stall,
    input  logic              id_redirect,
    input  logic [ADDR_W-1:0] id_target,
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_PC,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [ADDR_W-1:0] next_PC,
    output logic              flush_ex,
    output logic              flush_id,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam logic [ADDR_W-1:0] C_INSN_BYTES = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX    = '1;

    logic               mispredict;
    logic [ADDR_W-1:0]  correct_pc;
    next_pc_src_e       src_sel;
    logic [CNT_W-1:0]   mispredict_cnt_q;
    logic [CNT_W-1:0]   mispredict_cnt_d;

    btb_array #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_W       (CTR_W)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .rd_pc_i      (if_PC),
        .rd_taken_o   (pred_taken),
        .rd_target_o  (pred_target),
        .upd_valid_i  (ex_valid),
        .upd_pc_i     (ex_PC),
        .upd_taken_i  (ex_taken),
        .upd_target_i (ex_target)
    );

    // A resolved branch is mispredicted if the direction differs, or if it
    // was taken to a different target than the one carried down the pipe.
    always_comb begin
        mispredict = ex_valid &&
                     ((ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target)));
        correct_pc = ex_taken ? ex_target : (ex_PC + C_INSN_BYTES);
    end

    // Fixed priority; redirects beat stall because the stalled instruction
    // is on a wrong path anyway.
    always_comb begin
        src_sel = SRC_SEQ;
        if (mispredict) begin
            src_sel = SRC_EX;
        end else if (id_redirect) begin
            src_sel = SRC_ID;
        end else if (stall) begin
            src_sel = SRC_HOLD;
        end else if (pred_taken) begin
            src_sel = SRC_PRED;
        end
    end

    // Next-PC mux driven by the selected source.
    always_comb begin
        next_PC = PC_plus4;
        case (src_sel)
            SRC_EX:   next_PC = correct_pc;
            SRC_ID:   next_PC = id_target;
            SRC_HOLD: next_PC = if_PC;
            SRC_PRED: next_PC = pred_target;
            default:  next_PC = PC_plus4;
        endcase
    end

    // Flushes: EX squashes both younger stages; an ID redirect only matters
    // when EX is not already redirecting.
    always_comb begin
        flush_ex = mispredict;
        flush_id = id_redirect && !mispredict;
    end

    // Mispredict statistics counter, sticks at all-ones.
    always_comb begin
        mispredict_cnt_d = mispredict_cnt_q;
        if (mispredict && (mispredict_cnt_q != C_CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + C_CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt_q <= '0;
        end else begin
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`timescale 1ns/1ps
// Testbench for branch_predict_unit: directed scenarios with literal
// expectations plus a randomized run against a behavioural BTB model.
module tb_branch_predict_unit;

    localparam int ADDR_W = 64;
    localparam int NENT   = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] if_PC, PC_plus4, id_target, ex_PC, ex_target, ex_pred_target;
    logic              stall, id_redirect, ex_valid, ex_taken, ex_pred_taken;
    logic              pred_taken, flush_ex, flush_id;
    logic [ADDR_W-1:0] pred_target, next_PC;
    logic [CNT_W-1:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .ADDR_W(ADDR_W), .BTB_ENTRIES(NENT), .CTR_W(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .if_PC(if_PC), .PC_plus4(PC_plus4),
        .stall(stall), .id_redirect(id_redirect), .id_target(id_target),
        .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .pred_taken(pred_taken),
        .pred_target(pred_target), .next_PC(next_PC), .flush_ex(flush_ex),
        .flush_id(flush_id), .mispredict_cnt(mispredict_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  [NENT];
    logic [63:0] m_tag    [NENT];
    logic [63:0] m_target [NENT];
    int          m_ctr    [NENT];
    int          m_cnt;
    bit          model_ok = 0;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return pc / (4 * NENT);
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_mispredict();
        if (!ex_valid) return 0;
        if (ex_taken != ex_pred_taken) return 1;
        return ex_taken && (ex_target != ex_pred_target);
    endfunction

    // Model state advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
            end
            m_cnt = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (m_mispredict() && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (ex_valid) begin
                int k;
                k = idx_of(ex_PC);
                if (m_hit(ex_PC)) begin
                    if (ex_taken) begin
                        m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                        m_target[k] = ex_target;
                    end else begin
                        m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                    end
                end else if (ex_taken) begin
                    m_valid[k] = 1; m_tag[k] = tag_of(ex_PC);
                    m_target[k] = ex_target; m_ctr[k] = 2;
                end
            end
        end
    end

    // Compare process: every falling edge once the model is initialised.
    bit          e_pt, e_mp;
    logic [63:0] e_ptgt, e_next;
    always @(negedge clk) begin
        if (model_ok) begin
            e_pt   = m_hit(if_PC) && (m_ctr[idx_of(if_PC)] >= 2);
            e_ptgt = e_pt ? m_target[idx_of(if_PC)] : 64'd0;
            e_mp   = m_mispredict();
            if (e_mp)             e_next = ex_taken ? ex_target : ex_PC + 64'd4;
            else if (id_redirect) e_next = id_target;
            else if (stall)       e_next = if_PC;
            else if (e_pt)        e_next = e_ptgt;
            else                  e_next = PC_plus4;
            chk("m_pred_taken",  {63'd0, pred_taken}, {63'd0, e_pt});
            chk("m_pred_target", pred_target, e_ptgt);
            chk("m_next_PC",     next_PC, e_next);
            chk("m_flush_ex",    {63'd0, flush_ex}, {63'd0, e_mp});
            chk("m_flush_id",    {63'd0, flush_id}, {63'd0, id_redirect && !e_mp});
            chk("m_cnt",         {60'd0, mispredict_cnt}, 64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [63:0] pc);
        if_PC = pc;
        PC_plus4 = pc + 64'd4;
    endtask

    task automatic set_ex(input bit v, input logic [63:0] pc, input bit tk,
                          input logic [63:0] tgt, input bit ptk, input logic [63:0] ptgt);
        ex_valid = v; ex_PC = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic quiet();
        stall = 0; id_redirect = 0; id_target = 0;
        set_ex(0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [63:0] rnd_pc();
        logic [63:0] pc;
        pc = (64'($urandom_range(0, 2)) << 6) | (64'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 3) == 0) pc = pc | 64'h8000_0000_0000_0000;
        return pc;
    endfunction

    function automatic logic [63:0] rnd_tgt();
        return 64'h1000 + 64'($urandom_range(0, 5)) * 64'h10;
    endfunction

    initial begin
        reset = 1;
        quiet();
        set_pc(64'h100);
        // Reset asserted with a taken branch in EX: must not allocate.
        set_ex(1, 64'h100, 1, 64'h700, 0, 0);
        step(); step();
        reset = 0;
        quiet();

        // 1: empty BTB
        set_pc(64'h100); #1;
        chk("t1_pred_taken", {63'd0, pred_taken}, 64'd0);
        chk("t1_pred_target", pred_target, 64'd0);
        chk("t1_next_PC", next_PC, 64'h104);
        chk("t1_cnt", {60'd0, mispredict_cnt}, 64'd0);

        // 2: taken mispredict allocates
        set_ex(1, 64'h100, 1, 64'h200, 0, 0); #1;
        chk("t2_flush_ex", {63'd0, flush_ex}, 64'd1);
        chk("t2_next_PC", next_PC, 64'h200);
        step();
        quiet(); #1;
        chk("t2_cnt", {60'd0, mispredict_cnt}, 64'd1);
        chk("t2_pred_taken", {63'd0, pred_taken}, 64'd1);
        chk("t2_next_PC_pred", next_PC, 64'h200);

        // 3: train down to strongly not-taken, saturating at 0
        set_ex(1, 64'h100, 0, 64'h200, 1, 64'h200); #1;
        chk("t3_next_PC", next_PC, 64'h104);
        step();
        quiet(); #1;
        chk("t3_pred_after1", {63'd0, pred_taken}, 64'd0);
        set_ex(1, 64'h100, 0, 64'h200, 1, 64'h200); step();
        set_ex(1, 64'h100, 0, 64'h200, 1, 64'h200); step();
        quiet(); #1;
        chk("t3_pred_after3", {63'd0, pred_taken}, 64'd0);
        chk("t3_cnt", {60'd0, mispredict_cnt}, 64'd4);

        // 4: mispredict + id redirect + stall in the same cycle
        stall = 1; id_redirect = 1; id_target = 64'h400;
        set_ex(1, 64'h300, 1, 64'h500, 0, 0); #1;
        chk("t4_next_PC_ex", next_PC, 64'h500);
        chk("t4_flush_ex", {63'd0, flush_ex}, 64'd1);
        chk("t4_flush_id0", {63'd0, flush_id}, 64'd0);
        set_ex(0, 0, 0, 0, 0, 0); #1;
        chk("t4_next_PC_id", next_PC, 64'h400);
        chk("t4_flush_id1", {63'd0, flush_id}, 64'd1);
        id_redirect = 0; #1;
        chk("t4_next_PC_hold", next_PC, 64'h100);
        step();
        quiet();

        // 5: aliasing and read-during-write
        set_ex(1, 64'h140, 1, 64'h600, 0, 0); step();
        quiet(); set_pc(64'h100); #1;
        chk("t5_alias_miss", {63'd0, pred_taken}, 64'd0);
        chk("t5_alias_next", next_PC, 64'h104);
        set_pc(64'h140); #1;
        chk("t5_alias_hit", {63'd0, pred_taken}, 64'd1);
        chk("t5_alias_tgt", pred_target, 64'h600);
        set_ex(1, 64'h140, 0, 64'h600, 1, 64'h600); #1;
        chk("t5_rdw_old", {63'd0, pred_taken}, 64'd1);
        chk("t5_rdw_oldtgt", pred_target, 64'h600);
        step();
        quiet(); #1;
        chk("t5_rdw_new", {63'd0, pred_taken}, 64'd0);
        chk("t5_cnt", {60'd0, mispredict_cnt}, 64'd6);

        // Randomized run, checked by the compare process every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            set_pc(rnd_pc());
            stall = ($urandom_range(0, 3) == 0);
            id_redirect = ($urandom_range(0, 5) == 0);
            id_target = rnd_tgt();
            set_ex($urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 1) == 1,
                   rnd_tgt(), $urandom_range(0, 1) == 1, rnd_tgt());
            step();
        end
        reset = 0;
        quiet();

        // 6: counter saturation, then reset wins over a concurrent update
        for (int n = 0; n < 16; n++) begin
            set_ex(1, 64'h40 * 64'(n), 1, 64'h800, 0, 0);
            step();
        end
        quiet(); #1;
        chk("t6_cnt_sat", {60'd0, mispredict_cnt}, 64'hF);
        reset = 1;
        set_ex(1, 64'h200, 1, 64'h900, 0, 0);
        step();
        reset = 0;
        quiet();
        set_pc(64'h200); #1;
        chk("t6_cnt_clr", {60'd0, mispredict_cnt}, 64'd0);
        chk("t6_no_alloc", {63'd0, pred_taken}, 64'd0);
        set_pc(64'h3C0); #1;
        chk("t6_btb_clr", {63'd0, pred_taken}, 64'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
